// File: rtl/data_sram_resp_pkg.sv
// Shared types and constants for the data SRAM response path.
// FSM encodings, write-enable patterns and the latched request bundle.
package data_sram_resp_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   localparam logic [3:0] WEN_BYTE = 4'b0001;
   localparam logic [3:0] WEN_HALF = 4'b0011;
   localparam logic [3:0] WEN_WORD = 4'b1111;

   typedef struct packed {
      logic        en;
      logic [3:0]  wen;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

endpackage

// File: rtl/data_sram_bank.sv
// Four 8-bit lanes with per-lane synchronous write and a registered read port.
// Array contents are never reset; only the output register is.
module data_sram_bank #(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   input  logic          re,
   input  logic          rzero,
   output logic [31:0]   rdata
);

   logic [31:0] rd;

   for (genvar i = 0; i < 4; i++) begin : g_lane
      logic [7:0] mem [0:(1<<AW)-1];
      always_ff @(posedge clk) begin
         if (we[i]) mem[addr] <= wdata[8*i +: 8];
      end
      assign rd[8*i +: 8] = mem[addr];
   end

   always_ff @(posedge clk) begin
      if (rst) rdata <= 32'h0;
      else if (re) rdata <= rzero ? 32'h0 : rd;
   end

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM front end: request latching, wait-state FSM, error checks, stall.
// The committed request is the live input (no wait) or the latched copy.
module data_sram_resp
   import data_sram_resp_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        stallreq_mem,
   output logic        addr_err
);

   localparam logic [2:0] N = 3'(WAIT_CYCLES);
   localparam bit HAS_WAIT = (WAIT_CYCLES != 0);

   state_t     state;
   logic [2:0] cnt;
   req_t       lat;
   req_t       in_req;
   req_t       cur;
   logic       commit;
   logic       oor;
   logic       mis;
   logic       err;
   logic       last;

   assign in_req = '{en: data_sram_en, wen: data_sram_wen,
                     addr: data_sram_addr, wdata: data_sram_wdata};

   assign cur  = HAS_WAIT ? lat : in_req;
   assign last = (state == S_WAIT) && (cnt == N);

   assign commit = !rst && (HAS_WAIT ? (last && lat.en)
                                     : (state == S_IDLE && data_sram_en));

   assign oor = |cur.addr[31:ADDR_WIDTH+2];
   assign mis = ((cur.wen == WEN_WORD) && (cur.addr[1:0] != 2'b00)) ||
                ((cur.wen == WEN_HALF) && cur.addr[0]);
   assign err = oor || mis;

   assign stallreq_mem = !rst && HAS_WAIT &&
                         (((state == S_IDLE) && data_sram_en) ||
                          ((state == S_WAIT) && (cnt != N)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= 3'd0;
         lat      <= '0;
         addr_err <= 1'b0;
      end else begin
         addr_err <= commit && err;
         unique case (state)
            S_IDLE: begin
               if (data_sram_en && HAS_WAIT) begin
                  lat   <= in_req;
                  state <= S_WAIT;
                  cnt   <= 3'd1;
               end
            end
            S_WAIT: begin
               if (cnt == N) begin
                  state <= S_IDLE;
                  cnt   <= 3'd0;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   data_sram_bank #(
      .AW(ADDR_WIDTH)
   ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    ((commit && !err) ? cur.wen : 4'b0000),
      .addr  (cur.addr[ADDR_WIDTH+1:2]),
      .wdata (cur.wdata),
      .re    (commit && (cur.wen == 4'b0000)),
      .rzero (err),
      .rdata (data_sram_rdata)
   );

endmodule
